// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch types: FSM state encoding, default reset vector and the alignment helper.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_KILL  = 2'd1,
    ST_MISAL = 2'd2
  } fetch_state_t;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  // True when any bit below the fetch step granularity is set.
  function automatic logic misaligned64(input logic [63:0] addr, input int unsigned step);
    logic [63:0] mask;
    mask = 64'(step - 1);
    return (addr & mask) != '0;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch unit signal bundle: redirect inputs, instruction-memory request/response, decode-side slot.
interface fetch_pc_unit_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) ();

  logic            stall;
  logic            jump;
  logic [XLEN-1:0] jump_pc;
  logic            trap;
  logic [XLEN-1:0] trap_pc;
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_ok;
  logic [ILEN-1:0] iresp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_misalign;

  modport master (
    input  stall, jump, jump_pc, trap, trap_pc, iresp_ok, iresp_data,
    output ireq_valid, ireq_addr, if_valid, if_pc, if_instr, if_misalign
  );

  modport slave (
    output stall, jump, jump_pc, trap, trap_pc, iresp_ok, iresp_data,
    input  ireq_valid, ireq_addr, if_valid, if_pc, if_instr, if_misalign
  );

endinterface

// File: rtl/fetch_npc_sel.sv
// Next-PC selection: redirect priority (trap over jump), target alignment check, sequential increment.
module fetch_npc_sel
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PC_STEP = 4
) (
  input  logic            jump,
  input  logic [XLEN-1:0] jump_pc,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] pc,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            tgt_misal,
  output logic [XLEN-1:0] pc_seq
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  assign redirect  = trap | jump;
  assign target    = trap ? trap_pc : jump_pc;
  assign tgt_misal = redirect && misaligned64(64'(target), PC_STEP);
  assign pc_seq    = pc + STEP;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer with one registered instruction slot; response -> slot in 1 cycle, redirect -> new address in 1 cycle.
// Stall holds the slot and suppresses new requests; a fetch issued before a redirect is drained in KILL.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_unit_if.master bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] stale_addr;
  logic            misal_pend;

  logic            slot_vld;
  logic [XLEN-1:0] slot_pc;
  logic [ILEN-1:0] slot_instr;
  logic            slot_misal;

  logic            redirect;
  logic            tgt_misal;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_seq;
  logic            req_vld;
  logic            accept;

  fetch_npc_sel #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_npc_sel (
    .jump      (bus.jump),
    .jump_pc   (bus.jump_pc),
    .trap      (bus.trap),
    .trap_pc   (bus.trap_pc),
    .pc        (pc),
    .redirect  (redirect),
    .target    (target),
    .tgt_misal (tgt_misal),
    .pc_seq    (pc_seq)
  );

  always_comb begin
    req_vld = 1'b0;
    case (state)
      ST_REQ:  req_vld = !slot_vld || !bus.stall;
      ST_KILL: req_vld = 1'b1;
      default: req_vld = 1'b0;
    endcase
  end

  assign accept          = req_vld && bus.iresp_ok;
  assign bus.ireq_valid  = req_vld && !reset;
  assign bus.ireq_addr   = (state == ST_KILL) ? stale_addr : pc;
  assign bus.if_valid    = slot_vld;
  assign bus.if_pc       = slot_pc;
  assign bus.if_instr    = slot_instr;
  assign bus.if_misalign = slot_misal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      stale_addr <= '0;
      misal_pend <= 1'b0;
      slot_vld   <= 1'b0;
      slot_pc    <= '0;
      slot_instr <= '0;
      slot_misal <= 1'b0;
    end else if (redirect) begin
      // A misaligned target becomes a visible fault slot; an aligned one empties the slot.
      slot_vld   <= tgt_misal;
      slot_pc    <= target;
      slot_instr <= '0;
      slot_misal <= tgt_misal;
      if (!tgt_misal) pc <= target;
      case (state)
        ST_REQ: begin
          if (req_vld && !bus.iresp_ok) begin
            state      <= ST_KILL;
            stale_addr <= pc;
            misal_pend <= tgt_misal;
          end else begin
            state <= tgt_misal ? ST_MISAL : ST_REQ;
          end
        end
        ST_KILL: begin
          if (bus.iresp_ok) state <= tgt_misal ? ST_MISAL : ST_REQ;
          else              misal_pend <= tgt_misal;
        end
        default: state <= tgt_misal ? ST_MISAL : ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (accept) begin
            slot_vld   <= 1'b1;
            slot_pc    <= pc;
            slot_instr <= bus.iresp_data;
            slot_misal <= 1'b0;
            pc         <= pc_seq;
          end else if (slot_vld && !bus.stall) begin
            slot_vld <= 1'b0;
          end
        end
        ST_KILL: begin
          if (bus.iresp_ok) state <= misal_pend ? ST_MISAL : ST_REQ;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and random checks of fetch_pc_unit against a transaction-level reference model.
module tb_fetch_pc_unit;

  localparam int PC_STEP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.XLEN(64), .ILEN(32)) bus ();
  fetch_pc_unit_if #(.XLEN(32), .ILEN(32)) bus32 ();

  fetch_pc_unit #(
    .XLEN(64), .ILEN(32), .PC_STEP(PC_STEP), .RESET_PC(64'h8000_0000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  fetch_pc_unit #(
    .XLEN(32), .ILEN(32), .PC_STEP(PC_STEP), .RESET_PC(32'hFFFF_FFFC)
  ) dut32 (
    .clk(clk), .reset(reset), .bus(bus32)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: program counter, output slot, and whether a stale fetch
  // is being drained or a misaligned-target fault is blocking fetches.
  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } slot_t;

  slot_t       m_slot;
  logic [63:0] m_pc;
  logic [63:0] m_stale_addr;
  logic        m_stale;
  logic        m_fault;
  logic        e_ireq_v;
  logic [63:0] e_addr;
  logic [31:0] last_data;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc         = 64'h8000_0000;
    m_slot       = '{v: 1'b0, pc: 64'h0, instr: 32'h0, mis: 1'b0};
    m_stale      = 1'b0;
    m_stale_addr = 64'h0;
    m_fault      = 1'b0;
  endtask

  task automatic model_check(string tag);
    e_ireq_v = m_stale ? 1'b1 : (m_fault ? 1'b0 : (!m_slot.v || !bus.stall));
    e_addr   = m_stale ? m_stale_addr : m_pc;
    chk({tag, "/ireq_valid"}, 64'(bus.ireq_valid), 64'(e_ireq_v));
    if (e_ireq_v) chk({tag, "/ireq_addr"}, bus.ireq_addr, e_addr);
    chk({tag, "/if_valid"}, 64'(bus.if_valid), 64'(m_slot.v));
    if (m_slot.v) begin
      chk({tag, "/if_pc"}, bus.if_pc, m_slot.pc);
      chk({tag, "/if_instr"}, 64'(bus.if_instr), 64'(m_slot.instr));
      chk({tag, "/if_misalign"}, 64'(bus.if_misalign), 64'(m_slot.mis));
    end
  endtask

  task automatic model_update();
    logic        redir;
    logic [63:0] tgt;
    logic        mis;
    redir = bus.jump || bus.trap;
    tgt   = bus.trap ? bus.trap_pc : bus.jump_pc;
    mis   = (tgt % PC_STEP) != 0;
    if (m_stale) begin
      if (bus.iresp_ok) m_stale = 1'b0;
    end else if (redir) begin
      if (e_ireq_v && !bus.iresp_ok) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end
    end else if (!m_fault && e_ireq_v && bus.iresp_ok) begin
      m_slot = '{v: 1'b1, pc: m_pc, instr: bus.iresp_data, mis: 1'b0};
      m_pc   = m_pc + PC_STEP;
    end else if (!m_fault && m_slot.v && !bus.stall) begin
      m_slot.v = 1'b0;
    end
    if (redir) begin
      m_fault = mis;
      if (mis) m_slot = '{v: 1'b1, pc: tgt, instr: 32'h0, mis: 1'b1};
      else begin
        m_slot.v = 1'b0;
        m_pc     = tgt;
      end
    end
  endtask

  // Called at a falling edge: check outputs, then advance one clock.
  task automatic step(string tag);
    model_check(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.stall      = 1'b0;
    bus.jump       = 1'b0;
    bus.jump_pc    = 64'h0;
    bus.trap       = 1'b0;
    bus.trap_pc    = 64'h0;
    bus.iresp_ok   = 1'b0;
    bus.iresp_data = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus32.stall      = 1'b0;
    bus32.jump       = 1'b0;
    bus32.jump_pc    = 32'h0;
    bus32.trap       = 1'b0;
    bus32.trap_pc    = 32'h0;
    bus32.iresp_ok   = 1'b1;
    bus32.iresp_data = 32'h0000_0013;

    @(negedge clk);
    chk("rst_ireq_valid", 64'(bus.ireq_valid), 64'h0);
    chk("rst_if_valid", 64'(bus.if_valid), 64'h0);
    chk("rst32_ireq_valid", 64'(bus32.ireq_valid), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Back-to-back fetches from the reset vector; 32-bit instance wraps.
    for (int i = 0; i < 3; i++) begin
      bus.iresp_ok   = 1'b1;
      bus.iresp_data = $urandom;
      last_data      = bus.iresp_data;
      @(negedge clk);
      chk("seq_addr", bus.ireq_addr, 64'h8000_0000 + 64'(4 * i));
      if (i > 0) chk("seq_if_pc", bus.if_pc, 64'h8000_0000 + 64'(4 * (i - 1)));
      if (i < 2) chk("wrap32_addr", 64'(bus32.ireq_addr), (i == 0) ? 64'hFFFF_FFFC : 64'h0);
      step("seq");
    end

    // Stall holds the slot and blocks requests.
    bus.stall    = 1'b1;
    bus.iresp_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_req", 64'(bus.ireq_valid), 64'h0);
      chk("stall_if_pc", bus.if_pc, 64'h8000_0008);
      chk("stall_if_instr", 64'(bus.if_instr), 64'(last_data));
      step("stall");
    end
    bus.stall    = 1'b0;
    bus.iresp_ok = 1'b0;
    @(negedge clk);
    chk("stall_drop_req", 64'(bus.ireq_valid), 64'h1);
    chk("stall_drop_addr", bus.ireq_addr, 64'h8000_000C);
    step("stall_drop");
    @(negedge clk);
    step("wait_c");
    bus.iresp_ok   = 1'b1;
    bus.iresp_data = $urandom;
    @(negedge clk);
    step("fetch_c");

    // Jump while a fetch is outstanding: stale response is drained.
    bus.iresp_ok = 1'b0;
    @(negedge clk);
    chk("kill_pre_addr", bus.ireq_addr, 64'h8000_0010);
    step("kill_pre");
    bus.jump    = 1'b1;
    bus.jump_pc = 64'h8000_0100;
    @(negedge clk);
    step("kill_jump");
    idle();
    @(negedge clk);
    chk("kill_stale_addr", bus.ireq_addr, 64'h8000_0010);
    chk("kill_if_valid", 64'(bus.if_valid), 64'h0);
    step("kill_wait");
    bus.iresp_ok   = 1'b1;
    bus.iresp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    step("kill_resp");
    bus.iresp_ok = 1'b0;
    @(negedge clk);
    chk("kill_after_valid", 64'(bus.if_valid), 64'h0);
    chk("kill_after_addr", bus.ireq_addr, 64'h8000_0100);
    step("kill_after");
    bus.iresp_ok   = 1'b1;
    bus.iresp_data = $urandom;
    @(negedge clk);
    step("fetch_100");

    // Trap wins over a simultaneous jump.
    bus.jump    = 1'b1;
    bus.jump_pc = 64'h8000_0200;
    bus.trap    = 1'b1;
    bus.trap_pc = 64'h8000_1000;
    @(negedge clk);
    step("prio");
    idle();
    @(negedge clk);
    chk("prio_addr", bus.ireq_addr, 64'h8000_1000);
    chk("prio_if_valid", 64'(bus.if_valid), 64'h0);
    step("prio_after");

    // Misaligned target faults and blocks fetch until an aligned redirect.
    bus.jump     = 1'b1;
    bus.jump_pc  = 64'h8000_0102;
    bus.iresp_ok = 1'b1;
    @(negedge clk);
    step("misal_jump");
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.stall    = 1'($urandom);
      bus.iresp_ok = 1'($urandom);
      @(negedge clk);
      chk("misal_no_req", 64'(bus.ireq_valid), 64'h0);
      chk("misal_flag", 64'(bus.if_misalign), 64'h1);
      chk("misal_if_pc", bus.if_pc, 64'h8000_0102);
      step("misal_hold");
    end
    idle();
    bus.trap    = 1'b1;
    bus.trap_pc = 64'h8000_0300;
    @(negedge clk);
    step("misal_exit");
    idle();
    @(negedge clk);
    chk("misal_exit_addr", bus.ireq_addr, 64'h8000_0300);
    step("misal_exit_req");
    bus.jump    = 1'b1;
    bus.jump_pc = 64'h8000_0306;
    @(negedge clk);
    step("misal_via_kill");
    idle();
    @(negedge clk);
    chk("misal_kill_addr", bus.ireq_addr, 64'h8000_0300);
    step("misal_kill_wait");
    bus.iresp_ok = 1'b1;
    @(negedge clk);
    step("misal_kill_resp");
    idle();
    @(negedge clk);
    chk("misal_kill_done", 64'(bus.ireq_valid), 64'h0);
    step("misal_kill_done");
    bus.trap    = 1'b1;
    bus.trap_pc = 64'h8000_0400;
    @(negedge clk);
    step("misal_exit2");
    idle();
    @(negedge clk);
    step("outstanding_400");

    // Asynchronous reset while a fetch is outstanding.
    reset = 1'b1;
    #1;
    chk("arst_ireq_valid", 64'(bus.ireq_valid), 64'h0);
    chk("arst_if_valid", 64'(bus.if_valid), 64'h0);
    chk("arst_addr", bus.ireq_addr, 64'h8000_0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("arst_first_addr", bus.ireq_addr, 64'h8000_0000);
    step("arst_first");

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] tgt;
      bus.stall      = ($urandom_range(0, 2) == 0);
      bus.iresp_ok   = 1'($urandom);
      bus.iresp_data = $urandom;
      bus.jump       = ($urandom_range(0, 7) == 0);
      bus.trap       = ($urandom_range(0, 15) == 0);
      tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFC)};
      if ($urandom_range(0, 9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
      if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      bus.jump_pc = tgt;
      tgt = {$urandom, $urandom & 32'hFFFF_FFFC};
      if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      bus.trap_pc = tgt;
      @(negedge clk);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
